// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//  Shared definitions for the radix-2 FFT engines:
//   - legal LOG2_NFFT range
//   - engine state encoding
//   - bit-reversal, butterfly index and twiddle index helpers
//   - twiddle quantisation used to build the twiddle ROM at elaboration
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int  LOG2_NFFT_MIN = 3;
  localparam int  LOG2_NFFT_MAX = 10;
  localparam real FFT_PI        = 3.14159265358979323846;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } fft_state_e;

  // Reverse the low nbits bits of k.
  function automatic int bitrev(input int k, input int nbits);
    int r;
    r = 0;
    for (int i = 0; i < LOG2_NFFT_MAX; i++) begin
      if (i < nbits) r = (r << 1) | ((k >> i) & 1);
    end
    return r;
  endfunction

  // Upper operand index of butterfly b in stage s (span = 2**s).
  function automatic int bfly_top(input int b, input int s);
    return ((b >> s) << (s + 1)) | (b & ((1 << s) - 1));
  endfunction

  // Lower operand index: one span below the upper operand.
  function automatic int bfly_bot(input int b, input int s);
    return bfly_top(b, s) + (1 << s);
  endfunction

  // Twiddle ROM index for butterfly b of stage s in a 2**log2n point transform.
  function automatic int tw_index(input int b, input int s, input int log2n);
    return (b & ((1 << s) - 1)) << (log2n - 1 - s);
  endfunction

  // Rounded fixed-point twiddle component: cos(2*pi*idx/N) or -sin(2*pi*idx/N).
  function automatic int tw_quant(input int idx, input int log2n, input int frac_bits,
                                  input bit neg_sin);
    real ang;
    real v;
    ang = 2.0 * FFT_PI * real'(idx) / real'(1 << log2n);
    v   = neg_sin ? -$sin(ang) : $cos(ang);
    v   = v * real'(1 << frac_bits);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

endpackage

// File: rtl/fft_r2_iter_if.sv
// -----------------------------------------------------------------------------
// fft_r2_iter_if
//  Streaming bus of the iterative FFT engine: input sample stream with
//  per-frame mode bits, output bin stream, and the busy status flag.
//  slave  : the engine side
//  master : the upstream/downstream side (drives samples, accepts bins)
// -----------------------------------------------------------------------------
interface fft_r2_iter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         mode_inv;
  logic                         mode_scale;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_r;
  logic signed [DATA_WIDTH-1:0] in_i;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_r;
  logic signed [DATA_WIDTH-1:0] out_i;
  logic                         out_last;
  logic                         busy;

  modport slave (
    input  mode_inv, mode_scale, in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_last, busy
  );

  modport master (
    output mode_inv, mode_scale, in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_last, busy
  );
endinterface

// File: rtl/fft_r2_butterfly.sv
// -----------------------------------------------------------------------------
// fft_r2_butterfly
//  Combinational radix-2 DIT butterfly:  A' = A + W*B,  B' = A - W*B.
//  Ports:
//   a_r/a_i, b_r/b_i  signed operands, DATA_WIDTH
//   w_r/w_i           twiddle {cos, -sin}, Q1.(TW_WIDTH-2)
//   inv               1 = conjugate the twiddle (inverse transform)
//   scale             1 = arithmetic >>>1 on both results
//   ap_*/bp_*         results, DATA_WIDTH
//  W*B is formed at DATA_WIDTH+TW_WIDTH bits and shifted down with floor
//  rounding. Unscaled sums wrap; scaled sums are formed one bit wider so
//  the halving keeps the carry.
// -----------------------------------------------------------------------------
module fft_r2_butterfly #(
  parameter int DATA_WIDTH = 32,
  parameter int TW_WIDTH   = 18
) (
  input  logic signed [DATA_WIDTH-1:0] a_r,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_r,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [TW_WIDTH-1:0]   w_r,
  input  logic signed [TW_WIDTH-1:0]   w_i,
  input  logic                         inv,
  input  logic                         scale,
  output logic signed [DATA_WIDTH-1:0] ap_r,
  output logic signed [DATA_WIDTH-1:0] ap_i,
  output logic signed [DATA_WIDTH-1:0] bp_r,
  output logic signed [DATA_WIDTH-1:0] bp_i
);
  localparam int PW      = DATA_WIDTH + TW_WIDTH;
  localparam int XW      = DATA_WIDTH + 1;
  localparam int TW_FRAC = TW_WIDTH - 2;

  logic signed [TW_WIDTH-1:0]   w_i_eff;
  logic signed [PW-1:0]         b_r_x, b_i_x, w_r_x, w_i_x;
  logic signed [PW-1:0]         prod_r, prod_i;
  logic signed [DATA_WIDTH-1:0] wb_r, wb_i;
  logic signed [XW-1:0]         sum_r, sum_i, dif_r, dif_i;

  always_comb begin
    w_i_eff = inv ? -w_i : w_i;

    b_r_x = PW'(b_r);
    b_i_x = PW'(b_i);
    w_r_x = PW'(w_r);
    w_i_x = PW'(w_i_eff);

    prod_r = (b_r_x * w_r_x) - (b_i_x * w_i_x);
    prod_i = (b_r_x * w_i_x) + (b_i_x * w_r_x);

    // Arithmetic shift floors toward -inf before dropping back to DATA_WIDTH.
    wb_r = DATA_WIDTH'(prod_r >>> TW_FRAC);
    wb_i = DATA_WIDTH'(prod_i >>> TW_FRAC);

    sum_r = XW'(a_r) + XW'(wb_r);
    sum_i = XW'(a_i) + XW'(wb_i);
    dif_r = XW'(a_r) - XW'(wb_r);
    dif_i = XW'(a_i) - XW'(wb_i);

    ap_r = scale ? sum_r[XW-1:1] : sum_r[DATA_WIDTH-1:0];
    ap_i = scale ? sum_i[XW-1:1] : sum_i[DATA_WIDTH-1:0];
    bp_r = scale ? dif_r[XW-1:1] : dif_r[DATA_WIDTH-1:0];
    bp_i = scale ? dif_i[XW-1:1] : dif_i[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/fft_r2_iter.sv
// -----------------------------------------------------------------------------
// fft_r2_iter
//  Iterative in-place radix-2 DIT FFT/IFFT. One frame is streamed in
//  (stored bit-reversed), transformed with a single butterfly at one
//  butterfly per cycle (LOG2_NFFT*NFFT/2 cycles), then streamed out in
//  natural order.
//  Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   bus.slave  sample stream in (in_valid/in_ready, in_r/in_i, mode_inv,
//              mode_scale latched with sample 0), bin stream out
//              (out_valid/out_ready, out_r/out_i, out_last), busy
//  Twiddles are computed at elaboration into a constant ROM of NFFT/2
//  {cos, -sin} entries.
// -----------------------------------------------------------------------------
module fft_r2_iter
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int LOG2_NFFT  = 5,
  parameter int TW_WIDTH   = 18
) (
  input logic          clk,
  input logic          rst,
  fft_r2_iter_if.slave bus
);
  localparam int NFFT_POINTS = 1 << LOG2_NFFT;
  localparam int NHALF       = NFFT_POINTS / 2;
  localparam int AW          = LOG2_NFFT;
  localparam int TWAW        = LOG2_NFFT - 1;
  localparam int SW          = $clog2(LOG2_NFFT);

  if (LOG2_NFFT < LOG2_NFFT_MIN || LOG2_NFFT > LOG2_NFFT_MAX) begin : g_bad_log2
    $error("fft_r2_iter: LOG2_NFFT outside legal range");
  end
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("fft_r2_iter: FRAC_BITS must lie within DATA_WIDTH");
  end

  // Twiddle ROM
  logic signed [TW_WIDTH-1:0] tw_cos  [NHALF];
  logic signed [TW_WIDTH-1:0] tw_nsin [NHALF];

  for (genvar t = 0; t < NHALF; t++) begin : g_tw
    localparam int COS_Q  = tw_quant(t, LOG2_NFFT, TW_WIDTH - 2, 1'b0);
    localparam int NSIN_Q = tw_quant(t, LOG2_NFFT, TW_WIDTH - 2, 1'b1);
    assign tw_cos[t]  = TW_WIDTH'(COS_Q);
    assign tw_nsin[t] = TW_WIDTH'(NSIN_Q);
  end

  // Sample buffer
  logic signed [DATA_WIDTH-1:0] buf_r [NFFT_POINTS];
  logic signed [DATA_WIDTH-1:0] buf_i [NFFT_POINTS];

  // Control state
  fft_state_e      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;      // sample index in LOAD / bin index in UNLOAD
  logic [TWAW-1:0] bfly_q, bfly_d;    // butterfly within stage
  logic [SW-1:0]   stage_q, stage_d;
  logic            inv_q, inv_d;
  logic            scale_q, scale_d;

  logic            in_fire, out_fire;
  logic [AW-1:0]   load_addr, top_addr, bot_addr;
  logic [TWAW-1:0] tw_addr;

  logic signed [DATA_WIDTH-1:0] ap_r, ap_i, bp_r, bp_i;

  assign in_fire  = bus.in_valid  && (state_q == ST_LOAD);
  assign out_fire = bus.out_ready && (state_q == ST_UNLOAD);

  always_comb begin
    load_addr = AW'(bitrev(int'(idx_q), LOG2_NFFT));
    top_addr  = AW'(bfly_top(int'(bfly_q), int'(stage_q)));
    bot_addr  = AW'(bfly_bot(int'(bfly_q), int'(stage_q)));
    tw_addr   = TWAW'(tw_index(int'(bfly_q), int'(stage_q), LOG2_NFFT));
  end

  fft_r2_butterfly #(
    .DATA_WIDTH (DATA_WIDTH),
    .TW_WIDTH   (TW_WIDTH)
  ) u_bfly (
    .a_r   (buf_r[top_addr]),
    .a_i   (buf_i[top_addr]),
    .b_r   (buf_r[bot_addr]),
    .b_i   (buf_i[bot_addr]),
    .w_r   (tw_cos[tw_addr]),
    .w_i   (tw_nsin[tw_addr]),
    .inv   (inv_q),
    .scale (scale_q),
    .ap_r  (ap_r),
    .ap_i  (ap_i),
    .bp_r  (bp_r),
    .bp_i  (bp_i)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    bfly_d  = bfly_q;
    stage_d = stage_q;
    inv_d   = inv_q;
    scale_d = scale_q;

    unique case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          if (idx_q == '0) begin
            inv_d   = bus.mode_inv;
            scale_d = bus.mode_scale;
          end
          idx_d = idx_q + 1'b1;   // wraps to 0, ready for UNLOAD
          if (idx_q == AW'(NFFT_POINTS - 1)) begin
            state_d = ST_COMPUTE;
            bfly_d  = '0;
            stage_d = '0;
          end
        end
      end
      ST_COMPUTE: begin
        bfly_d = bfly_q + 1'b1;
        if (bfly_q == '1) begin
          if (stage_q == SW'(LOG2_NFFT - 1)) state_d = ST_UNLOAD;
          else                               stage_d = stage_q + 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (out_fire) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == '1) state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      bfly_q  <= '0;
      stage_q <= '0;
      inv_q   <= 1'b0;
      scale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bfly_q  <= bfly_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
      scale_q <= scale_d;
    end
  end

  // NOTE: the buffer is deliberately not reset; its contents are always overwritten by LOAD before use, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (state_q == ST_COMPUTE) begin
      buf_r[top_addr] <= ap_r;
      buf_i[top_addr] <= ap_i;
      buf_r[bot_addr] <= bp_r;
      buf_i[bot_addr] <= bp_i;
    end else if (in_fire) begin
      buf_r[load_addr] <= bus.in_r;
      buf_i[load_addr] <= bus.in_i;
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.busy      = (state_q == ST_COMPUTE);
  assign bus.out_valid = (state_q == ST_UNLOAD);
  assign bus.out_last  = (state_q == ST_UNLOAD) && (idx_q == '1);
  assign bus.out_r     = (state_q == ST_UNLOAD) ? buf_r[idx_q] : '0;
  assign bus.out_i     = (state_q == ST_UNLOAD) ? buf_i[idx_q] : '0;

endmodule
